// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game sequencer.
//   cell_t     : 2-bit cell code (empty / player 1 / player 2)
//   board_t    : 3x3 board of cells, indexed [row][col]
//   state_t    : game FSM states
//   WIN_DRAW   : winner code reported for a full board with no line
//   LINE_CELLS : flat cell indices (row*3+col) of the eight winning lines
package ttt_pkg;

    typedef enum logic [1:0] {
        CellEmpty = 2'b00,
        CellP1    = 2'b01,
        CellP2    = 2'b10
    } cell_t;

    typedef cell_t [2:0][2:0] board_t;

    typedef enum logic [1:0] {
        StWaitMove = 2'b00,
        StPlace    = 2'b01,
        StCheck    = 2'b10,
        StGameOver = 2'b11
    } state_t;

    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Lines 0-2 rows, 3-5 columns, 6 main diagonal, 7 anti-diagonal.
    localparam logic [3:0] LINE_CELLS [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/ttt_line_check.sv
// Combinational check of one winning line of the board.
//   iBOARD : board to inspect
//   iLINE  : line index 0..7 (see LINE_CELLS)
//   oMATCH : all three cells of the line equal and nonzero
//   oCODE  : code of the line's first cell (the winner when oMATCH is high)
module ttt_line_check
    import ttt_pkg::*;
(
    input  board_t     iBOARD,
    input  logic [2:0] iLINE,
    output logic       oMATCH,
    output cell_t      oCODE
);

    logic [17:0] flat;
    logic [1:0]  c0, c1, c2;

    always_comb begin
        // Cell i of the packed board lives at bits [2*i+1:2*i].
        flat   = iBOARD;
        c0     = flat[{LINE_CELLS[iLINE][0], 1'b0} +: 2];
        c1     = flat[{LINE_CELLS[iLINE][1], 1'b0} +: 2];
        c2     = flat[{LINE_CELLS[iLINE][2], 1'b0} +: 2];
        oMATCH = (c0 != 2'b00) && (c0 == c1) && (c1 == c2);
        oCODE  = cell_t'(c0);
    end

endmodule

// File: rtl/ttt_game_sequencer.sv
// Tic-tac-toe game controller for the VGA board renderer.
//   iVGA_CLK     : pixel clock
//   iRST_n       : synchronous reset, active HIGH
//   iVS          : vertical sync (active-low); its registered falling edge is the frame tick
//   iNEW_GAME    : restart pulse
//   iMOVE_VALID / iMOVE_POS / oMOVE_READY : move handshake, cell index row*3+col
//   oMOVE_REJECT : one-cycle pulse for an illegal move
//   oMATRIZ      : displayed board, refreshed from the shadow board on frame ticks only
//   oTURN        : player to move (0 = P1), oWINNER / oWIN_LINE / oGAME_OVER : result
module ttt_game_sequencer
    import ttt_pkg::*;
#(
    parameter int unsigned TIMEOUT_FRAMES = 600
) (
    input  logic                 iVGA_CLK,
    input  logic                 iRST_n,
    input  logic                 iVS,
    input  logic                 iNEW_GAME,
    input  logic                 iMOVE_VALID,
    input  logic [3:0]           iMOVE_POS,
    output logic                 oMOVE_READY,
    output logic                 oMOVE_REJECT,
    output logic [2:0][2:0][1:0] oMATRIZ,
    output logic                 oTURN,
    output logic [1:0]           oWINNER,
    output logic [2:0]           oWIN_LINE,
    output logic                 oGAME_OVER
);

    localparam int unsigned FcW = (TIMEOUT_FRAMES == 0) ? 1 : $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [FcW-1:0] TimeoutLast = FcW'(TIMEOUT_FRAMES - 1);

    state_t         state_q, state_d;
    logic [17:0]    shadow_q, shadow_d;
    logic [17:0]    matriz_q;
    logic [3:0]     moves_q, moves_d;
    logic           turn_q, turn_d;
    logic [1:0]     winner_q, winner_d;
    logic [2:0]     win_line_q, win_line_d;
    logic [2:0]     k_q, k_d;
    logic [FcW-1:0] fcnt_q, fcnt_d;
    logic           reject_q, reject_d;
    logic           place_ok_q, place_ok_d;
    logic           vs_q, tick_q;

    logic           pos_legal;
    logic [1:0]     cur_code;
    logic           line_match;
    cell_t          line_code;

    ttt_line_check u_line_check (
        .iBOARD (board_t'(shadow_q)),
        .iLINE  (k_q),
        .oMATCH (line_match),
        .oCODE  (line_code)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        moves_d    = moves_q;
        turn_d     = turn_q;
        winner_d   = winner_q;
        win_line_d = win_line_q;
        k_d        = k_q;
        fcnt_d     = fcnt_q;
        reject_d   = 1'b0;
        place_ok_d = place_ok_q;

        cur_code  = turn_q ? 2'b10 : 2'b01;
        // Out-of-range positions fail the first term, so the select below never matters for them.
        pos_legal = (iMOVE_POS <= 4'd8) && (shadow_q[{iMOVE_POS, 1'b0} +: 2] == 2'b00);

        unique case (state_q)
            StWaitMove: begin
                if (iMOVE_VALID) begin
                    // Legality is resolved at the handshake so PLACE already shows the result.
                    state_d = StPlace;
                    fcnt_d  = '0;
                    if (pos_legal) begin
                        shadow_d[{iMOVE_POS, 1'b0} +: 2] = cur_code;
                        moves_d    = moves_q + 4'd1;
                        place_ok_d = 1'b1;
                    end else begin
                        reject_d   = 1'b1;
                        place_ok_d = 1'b0;
                    end
                end else if (tick_q && (TIMEOUT_FRAMES != 0)) begin
                    if (fcnt_q == TimeoutLast) begin
                        turn_d = ~turn_q;
                        fcnt_d = '0;
                    end else if (fcnt_q != '1) begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            StPlace: begin
                k_d     = 3'd0;
                state_d = place_ok_q ? StCheck : StWaitMove;
            end
            StCheck: begin
                // Only the first matching line is latched.
                if (line_match && (winner_q == 2'b00)) begin
                    winner_d   = line_code;
                    win_line_d = k_q;
                end
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    if ((winner_q != 2'b00) || line_match) begin
                        state_d = StGameOver;
                    end else if (moves_q == 4'd9) begin
                        winner_d = WIN_DRAW;
                        state_d  = StGameOver;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = StWaitMove;
                    end
                end
            end
            StGameOver: begin
                state_d = StGameOver;
            end
            default: state_d = StWaitMove;
        endcase

        // A restart overrides everything, including a handshake in the same cycle.
        if (iNEW_GAME) begin
            state_d    = StWaitMove;
            shadow_d   = '0;
            moves_d    = 4'd0;
            turn_d     = 1'b0;
            winner_d   = 2'b00;
            win_line_d = 3'd0;
            k_d        = 3'd0;
            fcnt_d     = '0;
            reject_d   = 1'b0;
            place_ok_d = 1'b0;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST_n) begin
            state_q    <= StWaitMove;
            shadow_q   <= '0;
            matriz_q   <= '0;
            moves_q    <= 4'd0;
            turn_q     <= 1'b0;
            winner_q   <= 2'b00;
            win_line_q <= 3'd0;
            k_q        <= 3'd0;
            fcnt_q     <= '0;
            reject_q   <= 1'b0;
            place_ok_q <= 1'b0;
            vs_q       <= 1'b1;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            moves_q    <= moves_d;
            turn_q     <= turn_d;
            winner_q   <= winner_d;
            win_line_q <= win_line_d;
            k_q        <= k_d;
            fcnt_q     <= fcnt_d;
            reject_q   <= reject_d;
            place_ok_q <= place_ok_d;
            vs_q       <= iVS;
            tick_q     <= vs_q & ~iVS;
            // Copies the pre-write shadow if a move lands in the same cycle.
            if (tick_q) begin
                matriz_q <= shadow_q;
            end
        end
    end

    assign oMOVE_READY  = (state_q == StWaitMove);
    assign oGAME_OVER   = (state_q == StGameOver);
    assign oMOVE_REJECT = reject_q;
    assign oMATRIZ      = matriz_q;
    assign oTURN        = turn_q;
    assign oWINNER      = winner_q;
    assign oWIN_LINE    = win_line_q;

endmodule
